// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: circular FIFO with flush, exception cause per entry.
// Define INSTR_QUEUE_BYPASS_EN to present an incoming entry to decode in the same cycle when empty.
module instr_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  input  logic [63:0]            pc_i,
  input  logic [31:0]            inst_i,
  input  logic                   ex_valid_i,
  input  logic [63:0]            ex_cause_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic [63:0]            pc_o,
  output logic [31:0]            inst_o,
  output logic [63:0]            ex_cause_o,
  input  logic                   ready_i,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] CAUSE_NONE = 64'hFF;

  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   inst_mem  [DEPTH];
  logic [63:0]   cause_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          bypass;
  logic          push;
  logic          pop_mem;
  logic [63:0]   in_cause;

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass = (cnt_q == '0) && valid_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign in_cause = ex_valid_i ? ex_cause_i : CAUSE_NONE;
  assign ready_o  = (cnt_q != FULL);
  assign valid_o  = (cnt_q != '0) || bypass;
  assign count_o  = cnt_q;

  // A bypassed entry that decode takes immediately is never written.
  assign push    = valid_i && ready_o && !(bypass && ready_i);
  assign pop_mem = (cnt_q != '0) && ready_i;

  always_comb begin
    pc_o       = '0;
    inst_o     = NOP;
    ex_cause_o = CAUSE_NONE;
    if (bypass) begin
      pc_o       = pc_i;
      inst_o     = inst_i;
      ex_cause_o = in_cause;
    end else if (cnt_q != '0) begin
      pc_o       = pc_mem[rd_ptr_q];
      inst_o     = inst_mem[rd_ptr_q];
      ex_cause_o = cause_mem[rd_ptr_q];
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push)    wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_mem) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop_mem})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      pc_mem[wr_ptr_q]    <= pc_i;
      inst_mem[wr_ptr_q]  <= inst_i;
      cause_mem[wr_ptr_q] <= in_cause;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed scenarios followed by random traffic.
module tb_instr_queue;
  localparam int DEPTH = 4;
  localparam logic [63:0] NONE = 64'hFF;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] cause;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [63:0] pc_i = '0;
  logic [31:0] inst_i = '0;
  logic        ex_valid_i = 1'b0;
  logic [63:0] ex_cause_i = '0;
  logic        ready_o;
  logic        valid_o;
  logic [63:0] pc_o;
  logic [31:0] inst_o;
  logic [63:0] ex_cause_o;
  logic        ready_i = 1'b0;
  logic [$clog2(DEPTH):0] count_o;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .pc_i(pc_i), .inst_i(inst_i), .ex_valid_i(ex_valid_i), .ex_cause_i(ex_cause_i),
    .ready_o(ready_o), .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o),
    .ex_cause_o(ex_cause_o), .ready_i(ready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t exp_q[$];
  int   mcnt = 0;
  logic pend_push = 1'b0;
  logic pend_flush = 1'b0;
  ent_t pend_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: just before each rising edge, compare the presented head with the scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      #4;
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(valid_o), 64'd0);
        end else begin
          check("head_pc", pc_o, exp_q[0].pc);
          check("head_inst", 64'(inst_o), 64'(exp_q[0].inst));
          check("head_cause", ex_cause_o, exp_q[0].cause);
          if (ready_i && !rst_i) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_inst", 64'(inst_o), 64'h13);
        check("idle_pc", pc_o, 64'd0);
        check("idle_cause", ex_cause_o, NONE);
      end
    end
  end

  // One clock of stimulus; the reference model is a count plus an ordered list of entries.
  task automatic cyc(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                     input logic exv, input logic [63:0] cause, input logic rdy, input logic fl);
    logic byp, acc, pop;
    @(negedge clk_i);
    if (pend_flush) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_e);
    valid_i = v; pc_i = pc; inst_i = ins; ex_valid_i = exv; ex_cause_i = cause;
    ready_i = rdy; flush_i = fl;
    byp = 1'b0;
`ifdef INSTR_QUEUE_BYPASS_EN
    byp = v && !fl && (mcnt == 0);
`endif
    acc = v && !fl && (mcnt < DEPTH) && !(byp && rdy);
    pop = rdy && (mcnt > 0);
    pend_e = '{pc: pc, inst: ins, cause: (exv ? cause : NONE)};
    pend_flush = fl;
    pend_push = acc && !byp;
    if (byp) exp_q.push_back(pend_e);
    #1;
    check("count", 64'(count_o), 64'(mcnt));
    check("ready", 64'(ready_o), 64'(mcnt < DEPTH));
    check("valid", 64'(valid_o), 64'((mcnt != 0) || byp));
    if (fl) mcnt = 0;
    else mcnt = mcnt + int'(acc) - int'(pop);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 64'd0, 32'd0, 1'b0, 64'd0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; ex_valid_i = 1'b0;
    rst_i = 1'b1;
    exp_q.delete();
    mcnt = 0; pend_push = 1'b0; pend_flush = 1'b0;
    #2;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_inst", 64'(inst_o), 64'h13);
    check("rst_cause", ex_cause_o, NONE);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    do_reset();

    // First entry visible one cycle after the push, no exception.
    cyc(1'b1, 64'h8000_0000, 32'h00a0_0093, 1'b0, 64'h5, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Fill past capacity, then stream with decode draining.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 64'h1000 + 64'(i * 4), $urandom, 1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 64'h2000 + 64'(i * 4), $urandom, 1'b0, 64'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Exception cause carried to the head.
    cyc(1'b1, 64'h3000, 32'h0000_0073, 1'b1, 64'h01, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Flush with a simultaneous push: nothing survives.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 64'h4000 + 64'(i * 4), $urandom, 1'b0, 64'd0, 1'b0, 1'b0);
    cyc(1'b1, 64'hDEAD_0000, 32'hDEAD_BEEF, 1'b0, 64'd0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);

    // Empty queue, push and consume together.
    cyc(1'b1, 64'h5000, 32'h0010_0113, 1'b0, 64'd0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Reset mid-operation, then push on the first edge afterwards.
    cyc(1'b1, 64'h6000, $urandom, 1'b0, 64'd0, 1'b0, 1'b0);
    cyc(1'b1, 64'h6004, $urandom, 1'b0, 64'd0, 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, 64'h7000, 32'h0050_0293, 1'b0, 64'd0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom,
          $urandom_range(0, 4) == 0, 64'($urandom_range(0, 15)),
          $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
    end

    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    #6;
    check("drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of entries; power of two, at least 2.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port flush_i, input, 1 bit: discard all queued entries (mispredict or exception redirect).
REQ-005 SHALL have port valid_i, input, 1 bit: fetch stage presents an entry.
REQ-006 SHALL have port pc_i, input, 64 bits (XLEN): PC of the entry.
REQ-007 SHALL have port inst_i, input, 32 bits: raw instruction word.
REQ-008 SHALL have port ex_valid_i, input, 1 bit: fetch raised an exception for this entry.
REQ-009 SHALL have port ex_cause_i, input, 64 bits: exception cause code, meaningful only when ex_valid_i=1.
REQ-010 SHALL have port ready_o, output, 1 bit: queue accepts an entry this cycle.
REQ-011 SHALL have port valid_o, output, 1 bit: head entry available to decode.
REQ-012 SHALL have port pc_o, output, 64 bits: head PC.
REQ-013 SHALL have port inst_o, output, 32 bits: head instruction.
REQ-014 SHALL have port ex_cause_o, output, 64 bits: head exception cause; NONE (64'hFF) when the entry carries no exception.
REQ-015 SHALL have port ready_i, input, 1 bit: decode consumes the head entry.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-017 SHALL implement a circular FIFO with read pointer, write pointer and occupancy counter; both pointers wrap from DEPTH-1 to 0.
REQ-018 SHALL perform a push when valid_i && ready_o, and a pop when valid_o && ready_i.
REQ-019 SHALL drive ready_o = (count_o < DEPTH); a pop in the same cycle SHALL NOT raise ready_o when the queue is full.
REQ-020 SHALL drive valid_o = (count_o != 0), except as extended in REQ-029.
REQ-021 SHALL store ex_cause_i on a push when ex_valid_i=1, and 64'hFF otherwise.
REQ-022 SHALL, when valid_o=0, drive inst_o = 32'h00000013 (NOP), pc_o = 0 and ex_cause_o = 64'hFF.
REQ-023 SHALL leave count_o unchanged on a simultaneous push and pop, increment it on a push only and decrement it on a pop only.
REQ-024 SHALL, on flush_i=1, set count_o and both pointers to 0 on the next edge and discard any push or pop in that cycle; flush_i SHALL take priority over all other events.
REQ-025 SHALL have a minimum push-to-valid_o latency of 1 cycle, preserve FIFO order and never drop or duplicate an entry.

Reset
REQ-026 SHALL, while rst_i=1, asynchronously clear the pointers and the counter, so that valid_o=0, ready_o=1, count_o=0, inst_o=32'h00000013 and ex_cause_o=64'hFF.
REQ-027 SHALL NOT require reset of the storage array.
REQ-028 SHALL, on reset asserted mid-operation, lose all entries and accept new pushes on the first edge after rst_i deasserts.

Configuration
REQ-029 SHALL provide macro INSTR_QUEUE_BYPASS_EN. When the macro is defined and count_o=0 with valid_i=1 and flush_i=0, valid_o=1 in the same cycle and the outputs SHALL show the input entry combinationally. If ready_i=1 in that cycle, the entry is consumed and not written. When the macro is undefined, REQ-020 and REQ-025 apply unchanged.

Verification
REQ-030 SHALL cover: after reset, push inst 32'h00a00093 at pc 64'h80000000 with ready_i=0 -> the next cycle has valid_o=1, inst_o=32'h00a00093 and ex_cause_o=64'hFF.
REQ-031 SHALL cover: DEPTH=4, push 5 consecutive entries with ready_i=0 -> ready_o=0 after the 4th push, the 5th entry is not accepted and count_o=4.
REQ-032 SHALL cover: full queue with valid_i=1 and ready_i=1 for 8 cycles -> pops continue, pointers wrap, and output order matches push order.
REQ-033 SHALL cover: push with ex_valid_i=1 and ex_cause_i=64'h01 -> ex_cause_o=64'h01 at the head.
REQ-034 SHALL cover: 3 entries queued, then flush_i=1 together with a push -> next cycle count_o=0 and valid_o=0, and the pushed entry never appears.
REQ-035 SHALL cover: with INSTR_QUEUE_BYPASS_EN, empty queue, valid_i=1 and ready_i=1 -> valid_o=1 in the same cycle and count_o stays 0.
